// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants and types for the register-bank write arbiter.
package regbank_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} drain_state_t;
endpackage

// File: rtl/regbank_write_arbiter_if.sv
// regbank_write_arbiter_if: requester, bank-write, hazard and drain signals of the write arbiter.
interface regbank_write_arbiter_if;
    import regbank_pkg::*;
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0][REG_ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0]     req_data;
    logic                       drain_req;
    logic                       drain_done;
    logic                       writeBool;
    logic [REG_ADDR_W-1:0]      writeAddress;
    logic [DATA_W-1:0]          writeData;
    logic [REG_ADDR_W-1:0]      reg_1_Address;
    logic [REG_ADDR_W-1:0]      reg_2_Address;
    logic                       rs_busy;
    logic                       rt_busy;

    modport master (
        output req_valid, req_addr, req_data, drain_req, reg_1_Address, reg_2_Address,
        input  req_ready, drain_done, writeBool, writeAddress, writeData, rs_busy, rt_busy
    );
    modport slave (
        input  req_valid, req_addr, req_data, drain_req, reg_1_Address, reg_2_Address,
        output req_ready, drain_done, writeBool, writeAddress, writeData, rs_busy, rt_busy
    );
endinterface

// File: rtl/regbank_wr_fifo.sv
// regbank_wr_fifo: DEPTH-entry in-order write-request FIFO with head visible the cycle after push.
module regbank_wr_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wr_req_t din,
    output logic    full,
    output logic    empty,
    output wr_req_t head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    wr_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    assign full  = r_count == OCC_W'(DEPTH);
    assign empty = r_count == '0;
    assign head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (pop) r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + OCC_W'(push) - OCC_W'(pop);
        end
    end
endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: two FIFO'd writeback requesters share the bank write port, with hazard scoreboard and drain FSM.
// Define REGBANK_ARB_RR_EN for round-robin arbitration; otherwise req 0 (ALU) has fixed priority.
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic                    clk,
    input logic                    reset,
    regbank_write_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(2 * DEPTH + 2);

    drain_state_t          r_state, w_state_nxt;
    wr_req_t               w_push_req [2];
    wr_req_t               w_head [2];
    wr_req_t               w_win;
    logic [1:0]            w_full, w_empty, w_acc, w_grant;
    logic [CNT_W-1:0]      r_cnt [NUM_REGS];
    logic [CNT_W-1:0]      w_cnt_nxt [NUM_REGS];
    logic                  w_cnt_zero_nxt;
    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;

    assign bus.req_ready = {2{reset && r_state == RUN}} & ~w_full;
    assign w_acc         = bus.req_valid & bus.req_ready;

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        assign w_push_req[i] = '{addr: bus.req_addr[i], data: bus.req_data[i]};
        regbank_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (w_acc[i]),
            .pop   (w_grant[i]),
            .din   (w_push_req[i]),
            .full  (w_full[i]),
            .empty (w_empty[i]),
            .head  (w_head[i])
        );
    end

`ifdef REGBANK_ARB_RR_EN
    logic r_rr_ptr;
    assign w_grant = (!w_empty[0] && !w_empty[1]) ? (r_rr_ptr ? 2'b10 : 2'b01) : ~w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rr_ptr <= 1'b0;
        else if (|w_grant) r_rr_ptr <= w_grant[0];
    end
`else
    assign w_grant = {w_empty[0] & ~w_empty[1], ~w_empty[0]};
`endif

    assign w_win = w_grant[1] ? w_head[1] : w_head[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= |w_grant;
            if (|w_grant) begin
                r_wr_addr <= w_win.addr;
                r_wr_data <= w_win.data;
            end
        end
    end

    assign bus.writeBool    = r_wr_en;
    assign bus.writeAddress = r_wr_addr;
    assign bus.writeData    = r_wr_data;

    always_comb begin
        w_cnt_zero_nxt = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_cnt_nxt[r] = r_cnt[r]
                + CNT_W'(w_acc[0] && bus.req_addr[0] == REG_ADDR_W'(r))
                + CNT_W'(w_acc[1] && bus.req_addr[1] == REG_ADDR_W'(r))
                - CNT_W'(r_wr_en && r_wr_addr == REG_ADDR_W'(r));
            w_cnt_zero_nxt = w_cnt_zero_nxt && (w_cnt_nxt[r] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
        else for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= w_cnt_nxt[r];
    end

    assign bus.rs_busy = r_cnt[bus.reg_1_Address] != '0;
    assign bus.rt_busy = r_cnt[bus.reg_2_Address] != '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= RUN;
        else r_state <= w_state_nxt;
    end

    // Empty FIFOs plus all-zero next counters means the write now on the port is the last one,
    // so DONE is entered on the same edge that retires it.
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == RUN) ? (bus.drain_req ? DRAIN : RUN)
                    : !bus.drain_req ? RUN
                    : (r_state == DONE || (&w_empty && w_cnt_zero_nxt)) ? DONE : DRAIN;
    end

    assign bus.drain_done = r_state == DONE;
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: scoreboard bench for the register-bank write arbiter (DEPTH=2).
module tb_regbank_write_arbiter;
    import regbank_pkg::*;

`ifdef REGBANK_ARB_RR_EN
    localparam logic [7:0]  EXP_GRANT = 8'b1010_1010;
    localparam logic [7:0]  EXP_RDY1  = 8'b1010_1011;
    localparam logic [31:0] EXP_R7    = 32'd1;
`else
    localparam logic [7:0]  EXP_GRANT = 8'b1100_0000;
    localparam logic [7:0]  EXP_RDY1  = 8'b1100_0011;
    localparam logic [31:0] EXP_R7    = 32'd2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    wr_req_t q0[$];
    wr_req_t q1[$];
    int grants[$];
    logic [DATA_W-1:0] bank [NUM_REGS];

    regbank_write_arbiter_if bus();
    regbank_write_arbiter #(.DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Each write on the port must be the oldest outstanding entry of one requester.
    always @(negedge clk) begin
        if (reset && bus.writeBool) begin
            n_cmp++;
            if (q0.size() > 0 && bus.writeAddress === q0[0].addr && bus.writeData === q0[0].data) begin
                void'(q0.pop_front());
                grants.push_back(0);
            end else if (q1.size() > 0 && bus.writeAddress === q1[0].addr && bus.writeData === q1[0].data) begin
                void'(q1.pop_front());
                grants.push_back(1);
            end else begin
                n_bad++;
                $display("FAIL write_order: got addr %0d data %h, required the head of a requester queue (q0 %0d q1 %0d entries)",
                         bus.writeAddress, bus.writeData, q0.size(), q1.size());
            end
            bank[bus.writeAddress] = bus.writeData;
        end
    end

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_addr[0] = a0;
        bus.req_data[0] = d0;
        bus.req_addr[1] = a1;
        bus.req_data[1] = d1;
        #1;
        if (v[0] && bus.req_ready[0]) q0.push_back({a0, d0});
        if (v[1] && bus.req_ready[1]) q1.push_back({a1, d1});
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q0.size() > 0 || q1.size() > 0) && k < 40) begin
            drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
            k++;
        end
        n_cmp++;
        if (q0.size() + q1.size() != 0) begin
            n_bad++;
            $display("FAIL idle_timeout: %0d writes still outstanding, required 0", q0.size() + q1.size());
        end
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.req_ready, bus.writeBool, bus.writeAddress, bus.writeData, bus.rs_busy, bus.rt_busy, bus.drain_done} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: ready %b wb %b addr %0d data %h busy %b%b done %b, required all zero",
                     bus.req_ready, bus.writeBool, bus.writeAddress, bus.writeData, bus.rs_busy, bus.rt_busy, bus.drain_done);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_ready: got %b, required 11", bus.req_ready);
        end
    endtask

    task automatic test_contention();
        grants.delete();
        for (int c = 0; c < 6; c++)
            drive(2'b11, 5'd10, 32'(32'h1000 + c), 5'd11, 32'(32'h2000 + c));
        wait_idle();
        n_cmp++;
        if (grants.size() != 8) begin
            n_bad++;
            $display("FAIL contention_count: got %0d writes, required 8", grants.size());
        end
        for (int k = 0; k < 8 && k < grants.size(); k++) begin
            n_cmp++;
            if (grants[k] != int'(EXP_GRANT[k])) begin
                n_bad++;
                $display("FAIL contention_grant[%0d]: got req%0d, required req%0d", k, grants[k], EXP_GRANT[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 8; c++) begin
            drive((c < 4) ? 2'b11 : 2'b10, 5'd12, 32'(32'h3000 + c), 5'd13, 32'(32'h4000 + c));
            n_cmp++;
            if (bus.req_ready[1] !== EXP_RDY1[c]) begin
                n_bad++;
                $display("FAIL backpressure_ready1[%0d]: got %b, required %b", c, bus.req_ready[1], EXP_RDY1[c]);
            end
        end
        wait_idle();
    endtask

    task automatic test_single();
        bus.reg_1_Address = 5'd5;
        bus.reg_2_Address = 5'd6;
        drive(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0);
        n_cmp++;
        if (bus.rs_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_busy_t: got %b, required 0", bus.rs_busy);
        end
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        n_cmp++;
        if ({bus.rs_busy, bus.writeBool} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_t1: busy/wb got %b%b, required 10", bus.rs_busy, bus.writeBool);
        end
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        n_cmp++;
        if ({bus.writeBool, bus.writeAddress, bus.writeData, bus.rs_busy, bus.rt_busy} !== {1'b1, 5'd5, 32'hDEAD_BEEF, 2'b10}) begin
            n_bad++;
            $display("FAIL single_t2: wb %b addr %0d data %h busy %b%b, required 1 5 deadbeef 10",
                     bus.writeBool, bus.writeAddress, bus.writeData, bus.rs_busy, bus.rt_busy);
        end
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        n_cmp++;
        if ({bus.rs_busy, bus.writeBool} !== 2'b00) begin
            n_bad++;
            $display("FAIL single_t3: busy/wb got %b%b, required 00", bus.rs_busy, bus.writeBool);
        end
        wait_idle();
    endtask

    task automatic test_same_reg();
        logic [3:0] exp_busy = 4'b0111;
        bus.reg_1_Address = 5'd7;
        drive(2'b11, 5'd7, 32'd1, 5'd7, 32'd2);
        for (int c = 0; c < 4; c++) begin
            drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
            n_cmp++;
            if (bus.rs_busy !== exp_busy[c]) begin
                n_bad++;
                $display("FAIL same_reg_busy[%0d]: got %b, required %b", c + 1, bus.rs_busy, exp_busy[c]);
            end
        end
        n_cmp++;
        if (bank[7] !== EXP_R7) begin
            n_bad++;
            $display("FAIL same_reg_final: r7 got %h, required %h", bank[7], EXP_R7);
        end
        wait_idle();
    endtask

    task automatic test_drain();
        int last_wb = -1;
        int first_done = -1;
        drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
        drive(2'b01, 5'd3, 32'hA3, 5'd0, 32'd0);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.drain_req = 1'b1;
        n_cmp++;
        if (bus.req_ready !== 2'b11) begin
            n_bad++;
            $display("FAIL drain_ready_run: got %b, required 11", bus.req_ready);
        end
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        n_cmp++;
        if ({bus.req_ready, bus.drain_done} !== 3'b000) begin
            n_bad++;
            $display("FAIL drain_enter: ready %b done %b, required 00 0", bus.req_ready, bus.drain_done);
        end
        if (bus.writeBool) last_wb = 4;
        for (int c = 5; c <= 12; c++) begin
            drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
            if (bus.writeBool) last_wb = c;
            if (bus.drain_done && first_done < 0) first_done = c;
        end
        n_cmp++;
        if (last_wb != 5) begin
            n_bad++;
            $display("FAIL drain_last_write: cycle %0d, required 5", last_wb);
        end
        n_cmp++;
        if (first_done != 6) begin
            n_bad++;
            $display("FAIL drain_done_cycle: cycle %0d, required 6", first_done);
        end
        n_cmp++;
        if ({bus.drain_done, bus.req_ready} !== 3'b100) begin
            n_bad++;
            $display("FAIL drain_hold: done %b ready %b, required 1 00", bus.drain_done, bus.req_ready);
        end
        bus.drain_req = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        n_cmp++;
        if ({bus.drain_done, bus.req_ready} !== 3'b011) begin
            n_bad++;
            $display("FAIL drain_exit: done %b ready %b, required 0 11", bus.drain_done, bus.req_ready);
        end
        wait_idle();
    endtask

    task automatic test_async_reset();
        int stale = 0;
        bus.reg_1_Address = 5'd20;
        drive(2'b11, 5'd20, 32'h5A, 5'd21, 32'h5B);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        n_cmp++;
        if ({bus.writeBool, bus.rs_busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL async_pre: wb/busy got %b%b, required 11", bus.writeBool, bus.rs_busy);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.writeBool, bus.rs_busy, bus.req_ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_now: wb %b busy %b ready %b, required 0 0 00", bus.writeBool, bus.rs_busy, bus.req_ready);
        end
        q0.delete();
        q1.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
            if (bus.writeBool) stale++;
        end
        n_cmp++;
        if (stale != 0 || bus.req_ready !== 2'b11) begin
            n_bad++;
            $display("FAIL async_after: %0d stale writes ready %b, required 0 and 11", stale, bus.req_ready);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.drain_req = 1'b0;
        bus.reg_1_Address = '0;
        bus.reg_2_Address = '0;
        for (int r = 0; r < NUM_REGS; r++) bank[r] = '0;
        test_reset();
        test_contention();
        test_backpressure();
        test_single();
        test_same_reg();
        test_drain();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
